// File: rtl/sync_frame_pkg.sv
// Shared definitions for the transmit framer and the receive-side sync detector:
// sequencer states and the default frame geometry / header pattern.
package sync_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        PAYLOAD
    } state_t;

    localparam int          DEF_NBITS     = 8;
    localparam int          DEF_FRAME_LEN = 255;
    localparam int          DEF_SYNC_LEN  = 2;
    localparam logic [15:0] DEF_SYNC_WORD = 16'hF628;

endpackage

// File: rtl/sync_frame_outreg.sv
// Single-entry registered output stage. ld tells the sequencer when a new word
// may be loaded; a stalled word keeps its data and start-of-frame flag.
import sync_frame_pkg::*;

module sync_frame_outreg #(
    parameter int NBITS = DEF_NBITS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [NBITS-1:0] load_data,
    input  logic             load_sof,
    input  logic             out_ready,
    output logic             ld,
    output logic [NBITS-1:0] out_data,
    output logic             out_valid,
    output logic             out_sof
);

    logic [NBITS-1:0] data_reg;
    logic             valid_reg;
    logic             sof_reg;

    assign ld        = !valid_reg || out_ready;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign out_sof   = sof_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            sof_reg   <= 1'b0;
        end else if (ld) begin
            valid_reg <= load;
            if (load) begin
                data_reg <= load_data;
                sof_reg  <= load_sof;
            end
        end
    end

endmodule

// File: rtl/sync_frame_ctrl.sv
// Transmit frame sequencer: inserts an unscrambled SYNC header, then routes
// FRAME_LEN codeword words through the external scrambler into the output register.
import sync_frame_pkg::*;

module sync_frame_ctrl #(
    parameter int                        NBITS     = DEF_NBITS,
    parameter int                        FRAME_LEN = DEF_FRAME_LEN,
    parameter int                        SYNC_LEN  = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN*NBITS-1:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter bit                        RESEED    = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NBITS-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [NBITS-1:0] scr_din,
    input  logic [NBITS-1:0] scr_dout,
    output logic             scr_en,
    output logic             scr_rst,
    output logic [NBITS-1:0] out_data,
    output logic             out_valid,
    output logic             out_sof,
    input  logic             out_ready,
    output logic [15:0]      frame_cnt,
    output logic             err_sof
);

    localparam int PAY_W   = $clog2(FRAME_LEN);
    localparam int HDR_W   = $clog2(SYNC_LEN + 1);
    localparam int N_SLOTS = 1 << HDR_W;

    state_t           state_reg, state_next;
    logic [HDR_W-1:0] hdr_cnt_reg, hdr_cnt_next;
    logic [PAY_W-1:0] pay_cnt_reg, pay_cnt_next;
    logic [15:0]      frame_cnt_reg, frame_cnt_next;
    logic             err_sof_reg, err_sof_next;

    logic             ld;
    logic             load;
    logic             load_sof;
    logic [NBITS-1:0] load_data;
    logic             reseed_now;

    // Header split into words, MSB word first; slots past SYNC_LEN are never selected.
    logic [NBITS-1:0] sync_words [N_SLOTS];
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_sync
        if (gi < SYNC_LEN) begin : g_word
            assign sync_words[gi] = SYNC_WORD[(SYNC_LEN-1-gi)*NBITS +: NBITS];
        end else begin : g_pad
            assign sync_words[gi] = '0;
        end
    end

    assign scr_din   = in_data;
    assign scr_rst   = RST || reseed_now;
    assign frame_cnt = frame_cnt_reg;
    assign err_sof   = err_sof_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            hdr_cnt_reg   <= '0;
            pay_cnt_reg   <= '0;
            frame_cnt_reg <= '0;
            err_sof_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hdr_cnt_reg   <= hdr_cnt_next;
            pay_cnt_reg   <= pay_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
            err_sof_reg   <= err_sof_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hdr_cnt_next   = hdr_cnt_reg;
        pay_cnt_next   = pay_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        err_sof_next   = 1'b0;
        in_ready       = 1'b0;
        scr_en         = 1'b0;
        reseed_now     = 1'b0;
        load           = 1'b0;
        load_sof       = 1'b0;
        load_data      = scr_dout;
        case (state_reg)
            IDLE: begin
                // The start-of-codeword word stays on the input until PAYLOAD takes it.
                in_ready = !in_sof;
                if (in_valid) begin
                    if (in_sof) begin
                        state_next   = SYNC;
                        hdr_cnt_next = '0;
                        reseed_now   = RESEED;
                    end else begin
                        err_sof_next = 1'b1;
                    end
                end
            end
            SYNC: begin
                if (ld) begin
                    load         = 1'b1;
                    load_data    = sync_words[hdr_cnt_reg];
                    load_sof     = (hdr_cnt_reg == '0);
                    hdr_cnt_next = hdr_cnt_reg + 1'b1;
                    if (hdr_cnt_reg == HDR_W'(SYNC_LEN - 1)) begin
                        state_next   = PAYLOAD;
                        pay_cnt_next = '0;
                    end
                end
            end
            PAYLOAD: begin
                // Scrambler only advances when its output word is actually loaded.
                in_ready = ld;
                scr_en   = in_valid && ld;
                if (in_valid && ld) begin
                    load         = 1'b1;
                    pay_cnt_next = pay_cnt_reg + 1'b1;
                    if (in_sof && (pay_cnt_reg != '0)) begin
                        err_sof_next = 1'b1;
                    end
                    if (pay_cnt_reg == PAY_W'(FRAME_LEN - 1)) begin
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                        pay_cnt_next   = '0;
                        state_next     = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sync_frame_outreg #(
        .NBITS(NBITS)
    ) u_outreg (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .load_data(load_data),
        .load_sof (load_sof),
        .out_ready(out_ready),
        .ld       (ld),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_sof  (out_sof)
    );

endmodule

// File: tb/tb_sync_frame_ctrl.sv
// Directed bench for sync_frame_ctrl: two instances (reseeding and free-running)
// share stimulus, each driving its own x^16+x^5+x^4+x^3 additive scrambler.
module tb_sync_frame_ctrl;

    localparam int FL = 255;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, scr_en, scr_rst, out_valid, out_sof, err_sof;
    logic [7:0]  scr_din, scr_dout, out_data;
    logic [15:0] frame_cnt;
    logic        in_ready_nr, scr_en_nr, scr_rst_nr, out_valid_nr, out_sof_nr, err_sof_nr;
    logic [7:0]  scr_din_nr, scr_dout_nr, out_data_nr;
    logic [15:0] frame_cnt_nr;

    int n_vec = 0;
    int n_miss = 0;

    always #5 CLK = ~CLK;

    sync_frame_ctrl #(.RESEED(1'b1)) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .scr_din(scr_din), .scr_dout(scr_dout), .scr_en(scr_en),
        .scr_rst(scr_rst), .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
        .out_ready(out_ready), .frame_cnt(frame_cnt), .err_sof(err_sof)
    );

    sync_frame_ctrl #(.RESEED(1'b0)) dut_nr (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready_nr), .scr_din(scr_din_nr), .scr_dout(scr_dout_nr), .scr_en(scr_en_nr),
        .scr_rst(scr_rst_nr), .out_data(out_data_nr), .out_valid(out_valid_nr), .out_sof(out_sof_nr),
        .out_ready(out_ready), .frame_cnt(frame_cnt_nr), .err_sof(err_sof_nr)
    );

    // Bit-serial scrambler step, MSB first; returns {next_state, scrambled_byte}.
    function automatic logic [23:0] scr_step(input logic [15:0] st, input logic [7:0] d);
        logic [15:0] s;
        logic [7:0]  o;
        logic        fb;
        s = st;
        o = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            fb   = s[15] ^ s[4] ^ s[3] ^ s[2];
            o[i] = d[i] ^ fb;
            s    = {s[14:0], fb};
        end
        return {s, o};
    endfunction

    logic [15:0] lfsr, lfsr_n, lfsr_nr, lfsr_nr_n;
    always_comb {lfsr_n, scr_dout} = scr_step(lfsr, scr_din);
    always_comb {lfsr_nr_n, scr_dout_nr} = scr_step(lfsr_nr, scr_din_nr);
    always_ff @(posedge CLK) begin
        if (scr_rst) lfsr <= 16'hFFFF;
        else if (scr_en) lfsr <= lfsr_n;
        if (scr_rst_nr) lfsr_nr <= 16'hFFFF;
        else if (scr_en_nr) lfsr_nr <= lfsr_nr_n;
    end

    // out_ready owner: random or forced, updated 2 time units after each edge.
    bit rand_mode = 1'b0;
    bit ready_force = 1'b1;
    initial forever begin
        @(posedge CLK);
        #2;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [8:0] obs[$];
    logic [8:0] obs_nr[$];
    logic [8:0] exp_q[$];
    int stall_en_cnt = 0;
    int err_cnt = 0;
    int rst_cnt = 0;
    int rst_nr_cnt = 0;
    int lockstep_bad = 0;

    always @(negedge CLK) begin
        if (out_valid && out_ready) obs.push_back({out_sof, out_data});
        if (out_valid_nr && out_ready) obs_nr.push_back({out_sof_nr, out_data_nr});
        if (out_valid && !out_ready && scr_en) stall_en_cnt <= stall_en_cnt + 1;
        if (err_sof) err_cnt <= err_cnt + 1;
        if (scr_rst && !RST) rst_cnt <= rst_cnt + 1;
        if (scr_rst_nr && !RST) rst_nr_cnt <= rst_nr_cnt + 1;
        if (in_ready_nr !== in_ready || err_sof_nr !== err_sof || frame_cnt_nr !== frame_cnt)
            lockstep_bad <= lockstep_bad + 1;
    end

    task automatic drive(input logic [7:0] d, input logic sof);
        int n;
        n = 0;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL drive_timeout word=%02h: in_ready=%b required 1", d, in_ready);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input int nwords, input int err_idx);
        for (int i = 0; i < nwords; i++) drive(8'(i), (i == 0) || (i == err_idx));
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic add_exp_frame(input int nwords);
        logic [15:0] st;
        logic [7:0]  o;
        st = 16'hFFFF;
        exp_q.push_back({1'b1, 8'hF6});
        exp_q.push_back({1'b0, 8'h28});
        for (int i = 0; i < nwords; i++) begin
            {st, o} = scr_step(st, 8'(i));
            exp_q.push_back({1'b0, o});
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        n_vec++;
        if (scr_rst !== 1'b1) begin n_miss++; $display("FAIL rst_scr_rst: got %b required 1", scr_rst); end
        wait_cycles(2);
        RST = 1'b0;
        @(negedge CLK);
        n_vec++;
        if ({out_valid, out_sof, out_data, frame_cnt, err_sof} !== 27'd0) begin
            n_miss++;
            $display("FAIL rst_outputs: got valid=%b sof=%b data=%h fcnt=%0d err=%b required all 0",
                     out_valid, out_sof, out_data, frame_cnt, err_sof);
        end
        n_vec++;
        if (in_ready !== 1'b1 || scr_rst !== 1'b0 || scr_en !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_idle: got in_ready=%b scr_rst=%b scr_en=%b required 1 0 0", in_ready, scr_rst, scr_en);
        end
        $display("reset: out_valid=%b frame_cnt=%0d", out_valid, frame_cnt);
        @(posedge CLK);
        #1;
    endtask

    logic [8:0] nr_saved[$];
    logic [8:0] exp_nr[$];

    task automatic test_back_to_back();
        int c0, bad, r0;
        logic [15:0] st2;
        logic [7:0]  o;
        obs.delete(); obs_nr.delete(); exp_q.delete(); exp_nr.delete();
        r0 = rst_cnt;
        st2 = 16'hFFFF;
        for (int f = 0; f < 3; f++) begin
            add_exp_frame(FL);
            exp_nr.push_back({1'b1, 8'hF6});
            exp_nr.push_back({1'b0, 8'h28});
            for (int i = 0; i < FL; i++) begin
                {st2, o} = scr_step(st2, 8'(i));
                exp_nr.push_back({1'b0, o});
            end
        end
        for (int f = 0; f < 3; f++) begin
            c0 = cyc;
            send_frame(FL, -1);
            $display("b2b frame %0d: cycles=%0d frame_cnt=%0d", f + 1, cyc - c0, frame_cnt);
            n_vec++;
            if (frame_cnt !== 16'(f + 1)) begin n_miss++; $display("FAIL b2b_frame_cnt: got %0d required %0d", frame_cnt, f + 1); end
            n_vec++;
            if (cyc - c0 != FL + 3) begin n_miss++; $display("FAIL b2b_cycles: got %0d required %0d", cyc - c0, FL + 3); end
        end
        wait_cycles(3);
        n_vec++;
        if (obs.size() != exp_q.size()) begin n_miss++; $display("FAIL b2b_count: got %0d required %0d", obs.size(), exp_q.size()); end
        bad = -1;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) if (bad < 0 && obs[i] !== exp_q[i]) bad = i;
        n_vec++;
        if (bad >= 0) begin n_miss++; $display("FAIL b2b_stream idx=%0d: got %h required %h", bad, obs[bad], exp_q[bad]); end
        n_vec++;
        if (rst_cnt - r0 != 3) begin n_miss++; $display("FAIL b2b_reseeds: got %0d required 3", rst_cnt - r0); end
        nr_saved = obs_nr;
    endtask

    task automatic test_stall_random();
        int bad;
        obs.delete(); exp_q.delete();
        stall_en_cnt = 0;
        add_exp_frame(FL);
        add_exp_frame(FL);
        rand_mode = 1'b1;
        send_frame(FL, -1);
        send_frame(FL, -1);
        rand_mode = 1'b0;
        ready_force = 1'b1;
        wait_cycles(5);
        $display("stall: words_out=%0d frame_cnt=%0d", obs.size(), frame_cnt);
        n_vec++;
        if (obs.size() != exp_q.size()) begin n_miss++; $display("FAIL stall_count: got %0d required %0d", obs.size(), exp_q.size()); end
        bad = -1;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) if (bad < 0 && obs[i] !== exp_q[i]) bad = i;
        n_vec++;
        if (bad >= 0) begin n_miss++; $display("FAIL stall_stream idx=%0d: got %h required %h", bad, obs[bad], exp_q[bad]); end
        n_vec++;
        if (stall_en_cnt != 0) begin n_miss++; $display("FAIL stall_scr_en: got %0d stalled enables required 0", stall_en_cnt); end
        n_vec++;
        if (frame_cnt !== 16'd5) begin n_miss++; $display("FAIL stall_frame_cnt: got %0d required 5", frame_cnt); end
    endtask

    task automatic test_idle_drop();
        int e0;
        obs.delete();
        e0 = err_cnt;
        drive(8'hAA, 1'b0);
        n_vec++;
        if (err_sof !== 1'b1) begin n_miss++; $display("FAIL drop_err_pulse: got %b required 1", err_sof); end
        drive(8'hAA, 1'b0);
        drive(8'hAA, 1'b0);
        in_valid = 1'b0;
        wait_cycles(3);
        $display("idle drop: err pulses=%0d words_out=%0d", err_cnt - e0, obs.size());
        n_vec++;
        if (err_cnt - e0 != 3) begin n_miss++; $display("FAIL drop_err_count: got %0d required 3", err_cnt - e0); end
        n_vec++;
        if (obs.size() != 0) begin n_miss++; $display("FAIL drop_no_output: got %0d words required 0", obs.size()); end
        n_vec++;
        if (frame_cnt !== 16'd5) begin n_miss++; $display("FAIL drop_frame_cnt: got %0d required 5", frame_cnt); end
    endtask

    task automatic test_midframe_sof();
        int e0, bad;
        obs.delete(); exp_q.delete();
        e0 = err_cnt;
        add_exp_frame(FL);
        send_frame(FL, 100);
        wait_cycles(3);
        $display("midframe sof: err pulses=%0d words_out=%0d frame_cnt=%0d", err_cnt - e0, obs.size(), frame_cnt);
        n_vec++;
        if (err_cnt - e0 != 1) begin n_miss++; $display("FAIL msof_err_count: got %0d required 1", err_cnt - e0); end
        n_vec++;
        if (obs.size() != exp_q.size()) begin n_miss++; $display("FAIL msof_count: got %0d required %0d", obs.size(), exp_q.size()); end
        bad = -1;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) if (bad < 0 && obs[i] !== exp_q[i]) bad = i;
        n_vec++;
        if (bad >= 0) begin n_miss++; $display("FAIL msof_stream idx=%0d: got %h required %h", bad, obs[bad], exp_q[bad]); end
        n_vec++;
        if (frame_cnt !== 16'd6) begin n_miss++; $display("FAIL msof_frame_cnt: got %0d required 6", frame_cnt); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        obs.delete(); exp_q.delete();
        add_exp_frame(49);
        add_exp_frame(FL);
        send_frame(50, -1);
        RST = 1'b1;
        ready_force = 1'b0;
        @(negedge CLK);
        n_vec++;
        if (scr_rst !== 1'b1 || scr_rst_nr !== 1'b1) begin
            n_miss++; $display("FAIL rmid_scr_rst: got %b/%b required 1/1", scr_rst, scr_rst_nr);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        ready_force = 1'b1;
        @(negedge CLK);
        n_vec++;
        if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
        n_vec++;
        if (frame_cnt !== 16'd0) begin n_miss++; $display("FAIL rmid_frame_cnt0: got %0d required 0", frame_cnt); end
        @(posedge CLK);
        #1;
        send_frame(FL, -1);
        wait_cycles(3);
        $display("reset midframe: words_out=%0d frame_cnt=%0d", obs.size(), frame_cnt);
        n_vec++;
        if (frame_cnt !== 16'd1) begin n_miss++; $display("FAIL rmid_frame_cnt1: got %0d required 1", frame_cnt); end
        n_vec++;
        if (obs.size() != exp_q.size()) begin n_miss++; $display("FAIL rmid_count: got %0d required %0d", obs.size(), exp_q.size()); end
        bad = -1;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) if (bad < 0 && obs[i] !== exp_q[i]) bad = i;
        n_vec++;
        if (bad >= 0) begin n_miss++; $display("FAIL rmid_stream idx=%0d: got %h required %h", bad, obs[bad], exp_q[bad]); end
    endtask

    task automatic test_reseed_off();
        int bad, diff;
        bad = -1;
        for (int i = 0; i < nr_saved.size() && i < exp_nr.size(); i++) if (bad < 0 && nr_saved[i] !== exp_nr[i]) bad = i;
        n_vec++;
        if (nr_saved.size() != exp_nr.size()) begin n_miss++; $display("FAIL nr_count: got %0d required %0d", nr_saved.size(), exp_nr.size()); end
        n_vec++;
        if (bad >= 0) begin n_miss++; $display("FAIL nr_stream idx=%0d: got %h required %h", bad, nr_saved[bad], exp_nr[bad]); end
        diff = 0;
        for (int i = 2; i < FL + 2 && i + FL + 2 < nr_saved.size(); i++) if (nr_saved[i] !== nr_saved[i + FL + 2]) diff++;
        $display("reseed off: frame1 vs frame2 differing words=%0d scr_rst pulses=%0d", diff, rst_nr_cnt);
        n_vec++;
        if (diff == 0) begin n_miss++; $display("FAIL nr_frames_differ: got %0d differing words required >0", diff); end
        n_vec++;
        if (rst_nr_cnt != 0) begin n_miss++; $display("FAIL nr_no_reseed: got %0d pulses required 0", rst_nr_cnt); end
        n_vec++;
        if (lockstep_bad != 0) begin n_miss++; $display("FAIL nr_lockstep: got %0d divergent cycles required 0", lockstep_bad); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_random();
        test_idle_drop();
        test_midframe_sof();
        test_reset_midframe();
        test_reseed_off();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
